// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default geometry and the cleared-instruction value.
package instr_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF      = 8;
    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam logic [31:0] NOP_INSTR       = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_byte_assembler.sv
// fetch_byte_assembler: counts bytes of the current instruction and inserts
// each acknowledged byte little-endian into the assembled word.
module fetch_byte_assembler
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int unsigned CNT_W       = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic [7:0]               byte_in,
    output logic [CNT_W-1:0]         count,
    output logic [8*INSTR_BYTES-1:0] word,
    output logic                     last
);

    localparam logic [8*INSTR_BYTES-1:0] CLEAR_WORD = (8*INSTR_BYTES)'(NOP_INSTR);

    assign last = (count == CNT_W'(INSTR_BYTES - 1));

    // Byte counter and byte-lane insert; clear wins over load.
    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            count <= '0;
            word  <= CLEAR_WORD;
        end else if (load) begin
            for (int unsigned i = 0; i < INSTR_BYTES; i++) begin
                if (count == CNT_W'(i)) begin
                    word[8*i +: 8] <= byte_in;
                end
            end
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches INSTR_BYTES consecutive bytes starting at an
// accepted PC and presents the assembled instruction over valid/ready.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned PCs skip memory and
// return instr=0 with instr_err=1.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        pc_in,
    input  logic                     pc_valid,
    output logic                     pc_ready,
    input  logic                     flush,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_ack,
    output logic [8*INSTR_BYTES-1:0] instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     instr_err
);

    localparam int unsigned CNT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    fetch_state_t     state, state_nxt;
    logic             accept;
    logic             ack_ok;
    logic             misalign;
    logic             byte_last;
    logic [CNT_W-1:0] byte_cnt;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = (pc_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign accept = pc_valid && pc_ready;
    assign ack_ok = mem_rd && mem_ack && !flush;

    // Next-state and handshake outputs; flush overrides everything.
    always_comb begin
        state_nxt   = state;
        pc_ready    = 1'b0;
        instr_valid = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        case (state)
            IDLE: begin
                pc_ready = !flush && !rst_n;
                if (pc_valid && pc_ready) begin
                    state_nxt = misalign ? HOLD : FETCH;
                end
            end
            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = instr_pc + ADDR_W'(byte_cnt);
                if (mem_ack && byte_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                instr_valid = !flush;
                pc_ready    = instr_ready && !flush && !rst_n;
                if (instr_valid && instr_ready) begin
                    if (pc_valid && pc_ready) begin
                        state_nxt = misalign ? HOLD : FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture PC and error flag of each accepted request.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            instr_pc  <= '0;
            instr_err <= 1'b0;
        end else if (accept) begin
            instr_pc  <= pc_in;
            instr_err <= misalign;
        end
    end

    fetch_byte_assembler #(
        .INSTR_BYTES (INSTR_BYTES),
        .CNT_W       (CNT_W)
    ) u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .load    (ack_ok),
        .byte_in (mem_rdata),
        .count   (byte_cnt),
        .word    (instr),
        .last    (byte_last)
    );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the program counter. Accepts an 8-bit PC, reads four consecutive bytes from a byte-wide instruction memory port, and assembles them little-endian into a 32-bit instruction. Presents the instruction plus its PC to decode over a valid/ready handshake. Supports flush for PC redirects.

Parameters:
ADDR_W, 8, PC / memory byte-address width; addresses wrap modulo 2^ADDR_W.
INSTR_BYTES, 4, bytes per instruction, matching the PC step of 4.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-high reset; the port keeps the codebase name rst_n but asserts at 1
pc_in  input  ADDR_W  address of the next instruction
pc_valid  input  1  pc_in is valid
pc_ready  output  1  fetch unit accepts pc_in this cycle
flush  input  1  abandon current fetch or held instruction
mem_addr  output  ADDR_W  byte address to instruction memory
mem_rd  output  1  read request
mem_rdata  input  8  read data, valid with mem_ack
mem_ack  input  1  memory completes the current byte read
instr  output  32  assembled instruction
instr_pc  output  ADDR_W  PC of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decode consumes instruction
instr_err  output  1  misalignment flag, qualified by instr_valid; tied 0 without macro

Behaviour:
- Reset (rst_n=1, synchronous): state IDLE; byte count 0; pc_ready=1 only after reset releases; mem_rd=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, instr_err=0. Reset mid-fetch discards everything; a late mem_ack is ignored.
- FSM states: IDLE, FETCH, HOLD.
- IDLE: pc_ready=1 (gated low by flush). On pc_valid&pc_ready: latch pc into instr_pc, clear byte count and instr, and go to FETCH. mem_rd=1 and mem_addr=pc from the next cycle.
- FETCH: mem_rd=1. mem_addr = instr_pc + byte count, truncated to ADDR_W, so 0xFE wraps to 0xFE, 0xFF, 0x00, 0x01. mem_addr is held stable until mem_ack.
  - On mem_ack: store mem_rdata into byte [count] (byte0 -> instr[7:0]) and increment count.
  - On the ack of byte INSTR_BYTES-1: go to HOLD, with mem_rd=0 next cycle.
  - Back-to-back acks are allowed, giving 1 byte/cycle. Minimum latency from PC acceptance to instr_valid is 5 cycles with zero-wait memory.
- HOLD: instr_valid=1, with instr, instr_pc and instr_err stable until the transfer.
  - Transfer occurs on instr_valid&instr_ready.
  - pc_ready = instr_ready (&!flush). Simultaneous transfer and new PC acceptance goes straight to FETCH with no bubble. Transfer without a new PC goes to IDLE.
- flush: highest priority. Combinationally forces instr_valid=0 and pc_ready=0, so no transfer and no accept occur in that cycle. Next state is IDLE with mem_rd=0. A mem_ack in the flush cycle is ignored. instr keeps its stale value but is not valid.
- mem_ack while mem_rd=0 is ignored.
- pc_valid outside accept cycles is ignored, with no queuing.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: a PC accepted with pc_in[1:0]!=0 issues no memory read. FSM goes IDLE->HOLD with instr=0 and instr_err=1, so instr_valid rises the next cycle. Aligned PCs behave normally with instr_err=0.
- Undefined: no check. Misaligned PCs fetch 4 bytes from pc_in upward, with wrap. instr_err is constant 0.

Decomposition:
- Shared package: FSM state enum (IDLE/FETCH/HOLD), ADDR_W and INSTR_BYTES defaults, and the constant NOP_INSTR=32'h0.
- One natural sub-module: fetch_byte_assembler. It holds the byte counter and shift/insert into the 32-bit word, with clear and load-on-ack inputs. The FSM and handshakes stay in instr_fetch_unit.

Test Plan:
- Reset, then pc_in=0x00, zero-wait memory returning 0x13,0x00,0x00,0x00 -> mem_addr 00..03 on consecutive cycles; instr=0x00000013 and instr_pc=0x00 with instr_valid at cycle 5.
- Wait states: 2-cycle gaps before each mem_ack -> mem_addr held stable across gaps; mem_rd held high; instr correct once all 4 bytes arrive.
- Back-pressure: instr_ready=0 for 3 cycles while pc_valid=1 with 0x04 -> pc_ready=0, instr stable. When instr_ready rises, transfer and acceptance of 0x04 happen in the same cycle, and the next fetch starts at 0x04.
- Wrap: pc_in=0xFC then 0xFE (macro off) -> addresses FC,FD,FE,FF then FE,FF,00,01.
- Flush after the 2nd ack of a fetch at 0x08, with a concurrent mem_ack -> the ack is ignored, mem_rd=0 next cycle, state IDLE, no instr_valid. A new pc 0x20 then fetches correctly.
- Macro on, pc_in=0x06 -> no mem_rd; next cycle instr_valid=1, instr_err=1, instr=0. Reset asserted mid-FETCH in any test -> all outputs 0 the next cycle.
